// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU in one EXEC cycle,
// DIV/DIVU/REM/REMU by restoring division at one quotient bit per cycle.
// Divide-by-zero and signed overflow take the short EXEC path and return the
// architected results. Handshake outputs are decoded from the state register only.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q;        // raw a (EXEC) or shifting dividend magnitude (DIV)
  logic [XLEN-1:0] b_q;        // raw b (EXEC) or divisor magnitude (DIV)
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic            neg_quo_q;  // quotient must be negated at the end
  logic            neg_rem_q;  // remainder must be negated at the end
  logic [XLEN-1:0] result_q;

  // Accept-side decode of the incoming operation
  logic            accept;
  logic            in_signed;
  logic            special;
  logic [XLEN-1:0] a_mag_d;
  logic [XLEN-1:0] b_mag_d;

  // Datapath helpers
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   exec_result;
  logic [XLEN:0]     rem_shift;
  logic              trial_ok;
  logic [XLEN-1:0]   rem_d;
  logic [XLEN-1:0]   quo_d;
  logic [XLEN-1:0]   quo_fin;
  logic [XLEN-1:0]   rem_fin;
  logic [XLEN-1:0]   div_result;

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign result_o    = result_q;

  // Accept decode: signed-ness, special-case detection, operand magnitudes
  always_comb begin
    accept    = in_valid_i && (state_q == IDLE) && !flush_i;
    in_signed = !op_i[0];
    special   = (b_i == '0) || (in_signed && (a_i == MIN_VAL) && (&b_i));
    a_mag_d   = (in_signed && a_i[XLEN-1]) ? (~a_i + 1'b1) : a_i;
    b_mag_d   = (in_signed && b_i[XLEN-1]) ? (~b_i + 1'b1) : b_i;
  end

  // EXEC result: multiply family or the architected special divide results
  always_comb begin
    a_ext = {{XLEN{(op_q[1:0] != 2'b11) & a_q[XLEN-1]}}, a_q};
    b_ext = {{XLEN{(op_q[1:0] == 2'b01) & b_q[XLEN-1]}}, b_q};
    prod  = a_ext * b_ext;
    if (!op_q[2]) begin
      exec_result = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (b_q == '0) begin
      exec_result = op_q[1] ? a_q : '1;
    end else begin
      exec_result = op_q[1] ? '0 : a_q;
    end
  end

  // One restoring-division step plus the final sign correction
  always_comb begin
    rem_shift  = {rem_q, a_q[XLEN-1]};
    trial_ok   = (rem_shift >= {1'b0, b_q});
    rem_d      = trial_ok ? (rem_shift[XLEN-1:0] - b_q) : rem_shift[XLEN-1:0];
    quo_d      = {quo_q[XLEN-2:0], trial_ok};
    quo_fin    = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
    rem_fin    = neg_rem_q ? (~rem_d + 1'b1) : rem_d;
    div_result = op_q[1] ? rem_fin : quo_fin;
  end

  // Control FSM and all datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q      <= op_i;
            neg_quo_q <= in_signed && (a_i[XLEN-1] ^ b_i[XLEN-1]);
            neg_rem_q <= in_signed && a_i[XLEN-1];
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            if (!op_i[2] || special) begin
              a_q     <= a_i;
              b_q     <= b_i;
              state_q <= EXEC;
            end else begin
              a_q     <= a_mag_d;
              b_q     <= b_mag_d;
              state_q <= DIV;
            end
          end
        end
        EXEC: begin
          result_q <= exec_result;
          state_q  <= DONE;
        end
        DIV: begin
          a_q   <= {a_q[XLEN-2:0], 1'b0};
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            result_q <= div_result;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32): directed cases plus random operations checked
// against a plain-arithmetic model of the RISC-V M-extension results and latencies.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_VAL = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural result of an M-extension op, straight from the ISA rules
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] ux, uy, p;
    int          ix, iy;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    ix = $signed(x);
    iy = $signed(y);
    p  = '0;
    r  = '0;
    case (f3)
      3'd0: begin p = 64'(sx * sy); r = p[31:0]; end
      3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
      3'd2: begin p = 64'(sx * longint'(uy)); r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: r = (y == 0) ? 32'hFFFF_FFFF : (x == MIN_VAL && y == 32'hFFFF_FFFF) ? x : 32'(ix / iy);
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: r = (y == 0) ? x : (x == MIN_VAL && y == 32'hFFFF_FFFF) ? 32'h0 : 32'(ix % iy);
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Edges from accept to out_valid: one for multiply/special divide, XLEN otherwise
  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    if (!f3[2]) return 1;
    if (y == 0) return 1;
    if (!f3[0] && x == MIN_VAL && y == 32'hFFFF_FFFF) return 1;
    return XLEN;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    logic [31:0] exp;
    int lat;
    int exp_lat;
    bit got;
    exp = model(f3, x, y);
    exp_lat = model_lat(f3, x, y);
    @(negedge clk);
    check({tag, "_ready_before"}, in_ready, 1'b1);
    in_valid = 1'b1;
    op = f3;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom_range(0, 7));
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) got = 1;
      else begin
        check({tag, "_busy_wait"}, busy, 1'b1);
        check({tag, "_ready_wait"}, in_ready, 1'b0);
      end
    end
    check({tag, "_valid"}, got, 1'b1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_result"}, result, exp);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, in_ready, 1'b1);
    check({tag, "_idle_valid"}, out_valid, 1'b0);
    $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", f3, x, y, result, exp, lat);
  endtask

  initial begin
    bit seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    #12;
    check("reset_ready", in_ready, 1'b1);
    check("reset_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply family
    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 0);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    // Regular divides
    run_op("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 0);
    // Divide by zero
    run_op("div0",  3'd4, 32'd5, 32'd0, 0);
    run_op("divu0", 3'd5, 32'd5, 32'd0, 0);
    run_op("rem0",  3'd6, 32'd5, 32'd0, 0);
    run_op("remu0", 3'd7, 32'hFFFF_FFFF, 32'd0, 0);
    // Signed overflow
    run_op("div_ovf", 3'd4, MIN_VAL, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 3'd6, MIN_VAL, 32'hFFFF_FFFF, 0);
    // Backpressure: result held for 10 cycles
    run_op("divu_bp", 3'd5, 32'd100, 32'd7, 10);

    // Flush beats a simultaneous accept
    @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    op = 3'd4;
    a = 32'd50;
    b = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_accept_busy", busy, 1'b0);
    check("flush_accept_ready", in_ready, 1'b1);

    // Flush mid-divide at iteration 10
    @(negedge clk);
    in_valid = 1'b1;
    op = 3'd4;
    a = 32'd1000;
    b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_ready", in_ready, 1'b1);
    check("flush_busy", busy, 1'b0);
    check("flush_valid", out_valid, 1'b0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("flush_no_valid", seen, 1'b0);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 0);

    // Asynchronous reset mid-divide at iteration 20
    @(negedge clk);
    in_valid = 1'b1;
    op = 3'd4;
    a = 32'd123456;
    b = 32'd11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_result", result, 32'h0);
    check("arst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("remu_after_reset", 3'd7, 32'd9, 32'd4, 0);

    // Random operations, with some zero / small / overflow divisors and random backpressure
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(0, 3));
        1: begin ra = MIN_VAL; rb = 32'hFFFF_FFFF; end
        2: rb = rb >> $urandom_range(1, 31);
        default: ;
      endcase
      run_op("rand", rop, ra, rb, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
